// File: rtl/kid_motion_ctrl.sv
// rtl/kid_motion_ctrl.sv - per-tick player motion sequencer (jump/rise/fall FSM, facing, action).
// Optional air jump enabled by defining DOUBLE_JUMP_EN.
module kid_motion_ctrl #(
  parameter int JUMP_H  = 64,
  parameter int DJUMP_H = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] keys,
  input  logic [3:0] is_collide,
  output logic [3:0] is_move,
  output logic       direction,
  output logic [1:0] action
);

  localparam int MAX_H = (JUMP_H > DJUMP_H) ? JUMP_H : DJUMP_H;
  localparam int CW    = $clog2(MAX_H + 1);
  localparam logic [CW-1:0] JUMP_LOAD  = CW'(JUMP_H - 1);
  localparam logic [CW-1:0] DJUMP_LOAD = CW'(DJUMP_H - 1);

  localparam logic [1:0] GROUND = 2'd0;
  localparam logic [1:0] RISE   = 2'd1;
  localparam logic [1:0] FALL   = 2'd2;

`ifdef DOUBLE_JUMP_EN
  localparam logic AIR_EN = 1'b1;
`else
  localparam logic AIR_EN = 1'b0;
`endif

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_jumps_left;
  logic          r_jump_prev;
  logic [3:0]    r_is_move;
  logic          r_direction;
  logic [1:0]    r_action;

  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_jumps_nxt;
  logic          w_up;
  logic          w_dn;
  logic          w_jump_edge;
  logic          w_air_jump;
  logic          w_side;
  logic          w_left;
  logic          w_right;
  logic [3:0]    w_move;
  logic [1:0]    w_action_nxt;
  logic          w_unused;

  assign w_unused    = keys[1];
  assign w_jump_edge = keys[0] & ~r_jump_prev;
  assign w_air_jump  = AIR_EN & r_jumps_left & w_jump_edge & ~is_collide[0];
  assign w_side      = keys[2] ^ keys[3];
  assign w_left      = keys[2] & ~keys[3];
  assign w_right     = keys[3] & ~keys[2];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_jumps_nxt = r_jumps_left;
    w_up        = 1'b0;
    w_dn        = 1'b0;
    case (r_state)
      GROUND: begin
        if (w_jump_edge & ~is_collide[0]) begin
          w_state_nxt = RISE;
          w_cnt_nxt   = JUMP_LOAD;
          w_up        = 1'b1;
        end else if (w_jump_edge) begin
          w_state_nxt = GROUND;
        end else if (~is_collide[1]) begin
          w_state_nxt = FALL;
          w_dn        = 1'b1;
        end
      end
      RISE: begin
        if (w_air_jump) begin
          w_cnt_nxt   = DJUMP_LOAD;
          w_jumps_nxt = 1'b0;
          w_up        = 1'b1;
        end else if (is_collide[0] | ~keys[0] | (r_cnt == '0)) begin
          w_state_nxt = FALL;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          w_up      = 1'b1;
        end
      end
      default: begin
        // Air jump takes priority over landing on the same tick.
        if (w_air_jump) begin
          w_state_nxt = RISE;
          w_cnt_nxt   = DJUMP_LOAD;
          w_jumps_nxt = 1'b0;
          w_up        = 1'b1;
        end else if (is_collide[1]) begin
          w_state_nxt = GROUND;
          w_jumps_nxt = AIR_EN;
        end else begin
          w_state_nxt = FALL;
          w_dn        = 1'b1;
        end
      end
    endcase
  end

  assign w_move = {w_right & ~is_collide[3], w_left & ~is_collide[2], w_dn, w_up};

  always_comb begin
    w_action_nxt = 2'b00;
    case (w_state_nxt)
      RISE:    w_action_nxt = 2'b10;
      GROUND:  w_action_nxt = w_side ? 2'b01 : 2'b00;
      default: w_action_nxt = 2'b11;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FALL;
      r_cnt        <= '0;
      r_jumps_left <= 1'b0;
      r_jump_prev  <= 1'b0;
      r_is_move    <= 4'b0;
      r_direction  <= 1'b1;
      r_action     <= 2'b11;
    end else begin
      r_is_move <= 4'b0;
      if (tick) begin
        r_state      <= w_state_nxt;
        r_cnt        <= w_cnt_nxt;
        r_jumps_left <= w_jumps_nxt;
        r_jump_prev  <= keys[0];
        r_is_move    <= w_move;
        r_action     <= w_action_nxt;
        if (w_side) r_direction <= keys[3];
      end
    end
  end

  assign is_move   = r_is_move;
  assign direction = r_direction;
  assign action    = r_action;

endmodule

// File: tb/tb_kid_motion_ctrl.sv
// tb/tb_kid_motion_ctrl.sv - directed self-checking bench for kid_motion_ctrl (JUMP_H=4, DJUMP_H=3).
module tb_kid_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] keys = 4'b0;
  logic [3:0] is_collide = 4'b0;
  logic [3:0] is_move;
  logic       direction;
  logic [1:0] action;

  int n_pass  = 0;
  int n_total = 0;

  kid_motion_ctrl #(.JUMP_H(4), .DJUMP_H(3)) dut (
    .clk(clk), .rst(rst), .tick(tick), .keys(keys), .is_collide(is_collide),
    .is_move(is_move), .direction(direction), .action(action)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // One tick cycle, check registered outputs, then one idle cycle where is_move must drop.
  task automatic step(input string tag, input logic [3:0] k, input logic [3:0] c,
                      input logic [3:0] e_move, input logic [1:0] e_act, input logic e_dir);
    @(negedge clk);
    keys = k; is_collide = c; tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    chk({tag, ".move"}, is_move, e_move);
    chk({tag, ".act"}, {2'b0, action}, {2'b0, e_act});
    chk({tag, ".dir"}, {3'b0, direction}, {3'b0, e_dir});
    @(posedge clk); #1;
    chk({tag, ".gap"}, is_move, 4'b0000);
  endtask

  task automatic do_reset(input logic with_tick);
    @(negedge clk);
    rst = 1'b1; tick = with_tick; keys = 4'b0001; is_collide = 4'b0000;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0; tick = 1'b0; keys = 4'b0000;
  endtask

  initial begin
    do_reset(1'b1);
    #1;
    chk("rst.move", is_move, 4'b0000);
    chk("rst.act", {2'b0, action}, 4'b0011);
    chk("rst.dir", {3'b0, direction}, 4'b0001);

    // Landing from reset
    step("fall1", 4'b0000, 4'b0000, 4'b0010, 2'b11, 1'b1);
    step("fall2", 4'b0000, 4'b0000, 4'b0010, 2'b11, 1'b1);
    step("fall3", 4'b0000, 4'b0000, 4'b0010, 2'b11, 1'b1);
    step("land",  4'b0000, 4'b0010, 4'b0000, 2'b00, 1'b1);

    // Press and release between ticks: no jump
    @(negedge clk); keys = 4'b0001;
    @(negedge clk); keys = 4'b0000;
    step("blip", 4'b0000, 4'b0010, 4'b0000, 2'b00, 1'b1);

    // Full ground jump, 4 up pulses
    step("jmp1", 4'b0001, 4'b0010, 4'b0001, 2'b10, 1'b1);
    step("jmp2", 4'b0001, 4'b0000, 4'b0001, 2'b10, 1'b1);
    step("jmp3", 4'b0001, 4'b0000, 4'b0001, 2'b10, 1'b1);
    step("jmp4", 4'b0001, 4'b0000, 4'b0001, 2'b10, 1'b1);
    step("jtop", 4'b0001, 4'b0000, 4'b0000, 2'b11, 1'b1);
    step("jfal", 4'b0001, 4'b0000, 4'b0010, 2'b11, 1'b1);
    step("jlnd", 4'b0000, 4'b0010, 4'b0000, 2'b00, 1'b1);

    // Release cut after 2 pulses
    step("cut1", 4'b0001, 4'b0010, 4'b0001, 2'b10, 1'b1);
    step("cut2", 4'b0001, 4'b0000, 4'b0001, 2'b10, 1'b1);
    step("cut3", 4'b0000, 4'b0000, 4'b0000, 2'b11, 1'b1);
    step("cut4", 4'b0000, 4'b0000, 4'b0010, 2'b11, 1'b1);
    step("cutl", 4'b0000, 4'b0010, 4'b0000, 2'b00, 1'b1);

    // Ceiling hit on second rise tick
    step("ceil1", 4'b0001, 4'b0010, 4'b0001, 2'b10, 1'b1);
    step("ceil2", 4'b0001, 4'b0001, 4'b0000, 2'b11, 1'b1);
    step("ceill", 4'b0000, 4'b0010, 4'b0000, 2'b00, 1'b1);

    // Horizontal and facing
    step("hblk",  4'b0100, 4'b0110, 4'b0000, 2'b01, 1'b0);
    step("hboth", 4'b1100, 4'b0010, 4'b0000, 2'b00, 1'b0);
    step("hright",4'b1000, 4'b0010, 4'b1000, 2'b01, 1'b1);
    step("hleft", 4'b0100, 4'b0010, 4'b0100, 2'b01, 1'b0);

    // Walk off ledge, then air jump
    step("ledge", 4'b0000, 4'b0000, 4'b0010, 2'b11, 1'b0);
`ifdef DOUBLE_JUMP_EN
    step("dj1",  4'b0001, 4'b0000, 4'b0001, 2'b10, 1'b0);
    step("dj2",  4'b0001, 4'b0000, 4'b0001, 2'b10, 1'b0);
    step("dj3",  4'b0001, 4'b0000, 4'b0001, 2'b10, 1'b0);
    step("djtop",4'b0001, 4'b0000, 4'b0000, 2'b11, 1'b0);
    step("djrel",4'b0000, 4'b0000, 4'b0010, 2'b11, 1'b0);
    step("dj2nd",4'b0001, 4'b0000, 4'b0010, 2'b11, 1'b0);
`else
    step("dj1",  4'b0001, 4'b0000, 4'b0010, 2'b11, 1'b0);
    step("dj2",  4'b0001, 4'b0000, 4'b0010, 2'b11, 1'b0);
    step("dj3",  4'b0001, 4'b0000, 4'b0010, 2'b11, 1'b0);
    step("djtop",4'b0001, 4'b0000, 4'b0010, 2'b11, 1'b0);
    step("djrel",4'b0000, 4'b0000, 4'b0010, 2'b11, 1'b0);
    step("dj2nd",4'b0001, 4'b0000, 4'b0010, 2'b11, 1'b0);
`endif
    step("djlnd", 4'b0000, 4'b0010, 4'b0000, 2'b00, 1'b0);

    // Reset mid-jump, then land on next tick
    step("rj1", 4'b0001, 4'b0010, 4'b0001, 2'b10, 1'b0);
    do_reset(1'b1);
    #1;
    chk("rj.rst.move", is_move, 4'b0000);
    chk("rj.rst.act", {2'b0, action}, 4'b0011);
    chk("rj.rst.dir", {3'b0, direction}, 4'b0001);
    step("rjlnd", 4'b0000, 4'b0010, 4'b0000, 2'b00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
